// File: rtl/fitbit_display_sequencer_if.sv
// Start/done handshake between the display sequencer and the BCD/segment converter.
interface fitbit_display_sequencer_if;
   logic        conv_start;
   logic [13:0] conv_value;
   logic        conv_done;

   modport master (
      output conv_start,
      output conv_value,
      input  conv_done
   );

   modport slave (
      input  conv_start,
      input  conv_value,
      output conv_done
   );
endinterface

// File: rtl/fitbit_display_sequencer.sv
// Picks one of four activity metrics, clamps a snapshot to four digits and hands it to the
// BCD/segment converter on every 1 Hz refresh, optionally rotating metrics in auto mode.
module fitbit_display_sequencer #(
   parameter int unsigned CLK_HZ       = 100000000,
   parameter int unsigned DWELL_S      = 2,
   parameter int unsigned CONV_TIMEOUT = 1023
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       START,
   input  logic                       AUTO,
   input  logic [1:0]                 MODE,
   input  logic [13:0]                steps_in,
   input  logic [13:0]                miles_in,
   input  logic [13:0]                over32_in,
   input  logic [13:0]                highatime_in,
   fitbit_display_sequencer_if.master conv,
   output logic [1:0]                 disp_sel,
   output logic                       dp_en,
   output logic                       SI,
   output logic                       tick_1hz,
   output logic                       conv_err
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned DW = (DWELL_S > 1) ? $clog2(DWELL_S) : 1;
   localparam int unsigned TW = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;
   localparam logic [PW-1:0] PrescLast   = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DwellLast   = DW'(DWELL_S - 1);
   localparam logic [TW-1:0] TimeoutLast = TW'(CONV_TIMEOUT - 1);
   localparam logic [13:0]   MaxShown    = 14'd9999;

   typedef enum logic [1:0] {StIdle, StLoad, StWait, StShow} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          adv_q, adv_d;
   logic [TW-1:0] wcnt_q, wcnt_d;
   logic          cstart_q, cstart_d;
   logic [13:0]   value_q, value_d;
   logic [1:0]    sel_q, sel_d;
   logic          dp_q, dp_d;
   logic          si_q, si_d;
   logic          err_q, err_d;

   logic [1:0]    pick;
   logic [13:0]   raw;

   // Metric that the next LOAD would capture.
   always_comb begin
      pick = MODE;
      if (AUTO) begin
         pick = adv_q ? sel_q + 2'd1 : sel_q;
      end
      raw = steps_in;
      case (pick)
         2'd0:    raw = steps_in;
         2'd1:    raw = miles_in;
         2'd2:    raw = over32_in;
         default: raw = highatime_in;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      tick_d   = 1'b0;
      dwell_d  = dwell_q;
      adv_d    = adv_q;
      wcnt_d   = wcnt_q;
      cstart_d = 1'b0;
      value_d  = value_q;
      sel_d    = sel_q;
      dp_d     = dp_q;
      si_d     = si_q;
      err_d    = err_q;

      if (START && (state_q != StIdle)) begin
         if (presc_q == PrescLast) begin
            presc_d = '0;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else begin
         presc_d = '0;
      end

      if (!START) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StLoad;
               dwell_d = '0;
               adv_d   = 1'b0;
            end
            StLoad: begin
               sel_d    = pick;
               dp_d     = (pick == 2'd1);
               value_d  = (raw > MaxShown) ? MaxShown : raw;
               si_d     = (raw > MaxShown);
               adv_d    = 1'b0;
               wcnt_d   = '0;
               cstart_d = 1'b1;
               state_d  = StWait;
            end
            StWait: begin
               if (conv.conv_done) begin
                  state_d = StShow;
               end else if (wcnt_q == TimeoutLast) begin
                  err_d   = 1'b1;
                  state_d = StShow;
               end else begin
                  wcnt_d = wcnt_q + TW'(1);
               end
            end
            StShow: begin
               // Dwell only accumulates in auto mode, so re-enabling AUTO starts a fresh dwell.
               if (!AUTO) begin
                  dwell_d = '0;
                  adv_d   = 1'b0;
               end
               if (!AUTO && (MODE != sel_q)) begin
                  state_d = StLoad;
               end else if (tick_q) begin
                  state_d = StLoad;
                  if (AUTO) begin
                     if (dwell_q == DwellLast) begin
                        adv_d   = 1'b1;
                        dwell_d = '0;
                     end else begin
                        dwell_d = dwell_q + DW'(1);
                     end
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q  <= StIdle;
         presc_q  <= '0;
         tick_q   <= 1'b0;
         dwell_q  <= '0;
         adv_q    <= 1'b0;
         wcnt_q   <= '0;
         cstart_q <= 1'b0;
         value_q  <= '0;
         sel_q    <= '0;
         dp_q     <= 1'b0;
         si_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         tick_q   <= tick_d;
         dwell_q  <= dwell_d;
         adv_q    <= adv_d;
         wcnt_q   <= wcnt_d;
         cstart_q <= cstart_d;
         value_q  <= value_d;
         sel_q    <= sel_d;
         dp_q     <= dp_d;
         si_q     <= si_d;
         err_q    <= err_d;
      end
   end

   assign conv.conv_start = cstart_q;
   assign conv.conv_value = value_q;
   assign disp_sel        = sel_q;
   assign dp_en           = dp_q;
   assign SI              = si_q;
   assign tick_1hz        = tick_q;
   assign conv_err        = err_q;

endmodule
